// File: rtl/ff_bank_cfg.sv
// Bank of WIDTH run-time configurable flip-flops (D / T / JK / SR), with
// per-channel enable, SR-illegal policy, change pulses, sticky SR errors
// and a saturating change counter.
//
// Ports:
//   clk, rst   rising-edge clock, async active-high reset
//   en         per-channel enable (0 = hold, no error detect)
//   mode       2 bits per channel: 00 D, 01 T, 10 JK, 11 SR
//   a, b       D/T/J/S and K/R inputs
//   err_clr    sync clear of sr_err and cnt (new events win)
//   q, q_n     channel state and its complement
//   chg        registered per-channel change pulse
//   sr_err     sticky S=R=1 flags, any_err = |sr_err
//   cnt        saturating count of edges where any q bit changed
module ff_bank_cfg #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] RST_VAL  = '0,
    parameter int               SR11_POL = 0,
    parameter int               CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   en,
    input  logic [2*WIDTH-1:0] mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               err_clr,
    output logic [WIDTH-1:0]   q,
    output logic [WIDTH-1:0]   q_n,
    output logic [WIDTH-1:0]   chg,
    output logic [WIDTH-1:0]   sr_err,
    output logic               any_err,
    output logic [CNT_W-1:0]   cnt
);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] chg_q, chg_d;
    logic [WIDTH-1:0] sr_err_q, sr_err_d;
    logic [WIDTH-1:0] err_set;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_base;

    always_comb begin
        q_d     = q_q;
        err_set = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (en[i]) begin
                case (mode[2*i +: 2])
                    2'b00: q_d[i] = a[i];
                    2'b01: q_d[i] = a[i] ? ~q_q[i] : q_q[i];
                    2'b10: begin
                        case ({a[i], b[i]})
                            2'b00:   q_d[i] = q_q[i];
                            2'b01:   q_d[i] = 1'b0;
                            2'b10:   q_d[i] = 1'b1;
                            default: q_d[i] = ~q_q[i];
                        endcase
                    end
                    default: begin
                        case ({a[i], b[i]})
                            2'b00: q_d[i] = q_q[i];
                            2'b01: q_d[i] = 1'b0;
                            2'b10: q_d[i] = 1'b1;
                            default: begin
                                // Illegal S=R=1: flag it and apply the policy
                                err_set[i] = 1'b1;
                                case (SR11_POL)
                                    1:       q_d[i] = 1'b0;
                                    2:       q_d[i] = 1'b1;
                                    3:       q_d[i] = ~q_q[i];
                                    default: q_d[i] = q_q[i];
                                endcase
                            end
                        endcase
                    end
                endcase
            end
        end
    end

    // Clear first, then new events are OR-ed / counted on top so they win
    always_comb begin
        chg_d    = q_d ^ q_q;
        sr_err_d = (err_clr ? '0 : sr_err_q) | err_set;
        cnt_base = err_clr ? '0 : cnt_q;
        cnt_d    = cnt_base;
        if ((|chg_d) && (cnt_base != '1)) begin
            cnt_d = cnt_base + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q      <= RST_VAL;
            chg_q    <= '0;
            sr_err_q <= '0;
            cnt_q    <= '0;
        end else begin
            q_q      <= q_d;
            chg_q    <= chg_d;
            sr_err_q <= sr_err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign q       = q_q;
    assign q_n     = ~q_q;
    assign chg     = chg_q;
    assign sr_err  = sr_err_q;
    assign any_err = |sr_err_q;
    assign cnt     = cnt_q;

endmodule

// File: tb/tb_ff_bank_cfg.sv
// Scoreboard bench for ff_bank_cfg: four instances, one per SR11_POL,
// all with RST_VAL=8'hA5 and CNT_W=3, driven with identical stimulus.
module tb_ff_bank_cfg;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  en, a, b;
    logic [15:0] mode;
    logic        err_clr;

    logic [7:0] q_o   [4];
    logic [7:0] qn_o  [4];
    logic [7:0] chg_o [4];
    logic [7:0] err_o [4];
    logic       ae_o  [4];
    logic [2:0] cnt_o [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        ff_bank_cfg #(
            .WIDTH(8), .RST_VAL(8'hA5), .SR11_POL(g), .CNT_W(3)
        ) u_dut (
            .clk(clk), .rst(rst), .en(en), .mode(mode),
            .a(a), .b(b), .err_clr(err_clr),
            .q(q_o[g]), .q_n(qn_o[g]), .chg(chg_o[g]),
            .sr_err(err_o[g]), .any_err(ae_o[g]), .cnt(cnt_o[g])
        );
    end

    typedef struct packed {
        logic [3:0][7:0] q;
        logic [3:0][7:0] chg;
        logic [3:0][7:0] err;
        logic [3:0][2:0] cnt;
    } exp_t;

    exp_t sb[$];

    logic [3:0][7:0] mq, merr;
    logic [3:0][2:0] mcnt;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input int k,
                       input logic [7:0] obs, input logic [7:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, obs, exp_v);
        end
    endtask

    function automatic logic [7:0] mnext(input logic [7:0] cq, input int pol,
                                         input logic [7:0] ien,
                                         input logic [15:0] imode,
                                         input logic [7:0] ia, input logic [7:0] ib);
        logic [7:0] r;
        r = cq;
        for (int i = 0; i < 8; i++) begin
            if (ien[i]) begin
                case (imode[2*i +: 2])
                    2'd0: r[i] = ia[i];
                    2'd1: if (ia[i]) r[i] = ~cq[i];
                    2'd2: begin
                        if (ia[i] && ib[i]) r[i] = ~cq[i];
                        else if (ia[i]) r[i] = 1'b1;
                        else if (ib[i]) r[i] = 1'b0;
                    end
                    default: begin
                        if (ia[i] && ib[i]) begin
                            if (pol == 1) r[i] = 1'b0;
                            else if (pol == 2) r[i] = 1'b1;
                            else if (pol == 3) r[i] = ~cq[i];
                        end else if (ia[i]) r[i] = 1'b1;
                        else if (ib[i]) r[i] = 1'b0;
                    end
                endcase
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] mset(input logic [7:0] ien,
                                        input logic [15:0] imode,
                                        input logic [7:0] ia, input logic [7:0] ib);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < 8; i++)
            s[i] = ien[i] && (imode[2*i +: 2] == 2'd3) && ia[i] && ib[i];
        return s;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            mq[k] = 8'hA5; merr[k] = 8'h00; mcnt[k] = 3'd0;
        end
    endtask

    task automatic step(input logic [7:0] ien, input logic [15:0] imode,
                        input logic [7:0] ia, input logic [7:0] ib,
                        input logic iclr);
        exp_t e;
        logic [7:0] nq;
        logic [2:0] c;
        en = ien; mode = imode; a = ia; b = ib; err_clr = iclr;
        for (int k = 0; k < 4; k++) begin
            nq       = mnext(mq[k], k, ien, imode, ia, ib);
            e.q[k]   = nq;
            e.chg[k] = nq ^ mq[k];
            e.err[k] = (iclr ? 8'h00 : merr[k]) | mset(ien, imode, ia, ib);
            c = iclr ? 3'd0 : mcnt[k];
            if (e.chg[k] != 8'h00 && c != 3'd7) c = c + 3'd1;
            e.cnt[k] = c;
            mq[k] = nq; merr[k] = e.err[k]; mcnt[k] = c;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 0, 8'h00, 8'h01);
        end else begin
            e = sb.pop_front();
            for (int k = 0; k < 4; k++) begin
                chk("q", k, q_o[k], e.q[k]);
                chk("q_n", k, qn_o[k], ~e.q[k]);
                chk("chg", k, chg_o[k], e.chg[k]);
                chk("sr_err", k, err_o[k], e.err[k]);
                chk("any_err", k, {7'b0, ae_o[k]}, {7'b0, |e.err[k]});
                chk("cnt", k, {5'b0, cnt_o[k]}, {5'b0, e.cnt[k]});
            end
        end
    endtask

    task automatic chk_reset(input string tag);
        for (int k = 0; k < 4; k++) begin
            chk({tag, "_q"}, k, q_o[k], 8'hA5);
            chk({tag, "_qn"}, k, qn_o[k], 8'h5A);
            chk({tag, "_chg"}, k, chg_o[k], 8'h00);
            chk({tag, "_err"}, k, err_o[k], 8'h00);
            chk({tag, "_any"}, k, {7'b0, ae_o[k]}, 8'h00);
            chk({tag, "_cnt"}, k, {5'b0, cnt_o[k]}, 8'h00);
        end
    endtask

    initial begin
        int sw_m [7];
        int sw_a [7];
        int sw_b [7];
        int sw_q [7];
        int sw_c [7];
        int pol_q [4];
        sw_m = '{0, 0, 1, 2, 2, 3, 1};
        sw_a = '{0, 1, 1, 1, 1, 0, 0};
        sw_b = '{0, 0, 0, 0, 1, 1, 0};
        sw_q = '{0, 1, 0, 1, 0, 0, 0};
        sw_c = '{1, 1, 1, 1, 1, 0, 0};
        pol_q = '{1, 0, 1, 0};

        rst = 1'b1; en = '0; mode = '0; a = '0; b = '0; err_clr = 1'b0;
        model_reset();
        #1;
        chk_reset("rst0");
        @(negedge clk);
        rst = 1'b0;

        // Mode sweep on channel 0
        for (int s = 0; s < 7; s++) begin
            step(8'h01, 16'(sw_m[s]), 8'(sw_a[s]), 8'(sw_b[s]), 1'b0);
            for (int k = 0; k < 4; k++) begin
                chk("sweep_q0", k, {7'b0, q_o[k][0]}, 8'(sw_q[s]));
                chk("sweep_chg0", k, {7'b0, chg_o[k][0]}, 8'(sw_c[s]));
            end
        end

        // SR11 policy per instance, then same with en0=0
        step(8'h01, 16'h0000, 8'h01, 8'h00, 1'b1);
        step(8'h01, 16'h0003, 8'h01, 8'h01, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk("sr11_q0", k, {7'b0, q_o[k][0]}, 8'(pol_q[k]));
            chk("sr11_err", k, err_o[k], 8'h01);
            chk("sr11_any", k, {7'b0, ae_o[k]}, 8'h01);
        end
        step(8'h01, 16'h0000, 8'h01, 8'h00, 1'b1);
        step(8'h00, 16'h0003, 8'h01, 8'h01, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk("sr11_dis_q0", k, {7'b0, q_o[k][0]}, 8'h01);
            chk("sr11_dis_err", k, err_o[k], 8'h00);
        end

        // err_clr alone, then err_clr racing a new SR11 on ch3
        step(8'h01, 16'h0003, 8'h01, 8'h01, 1'b0);
        step(8'h00, 16'h0000, 8'h00, 8'h00, 1'b1);
        for (int k = 0; k < 4; k++) begin
            chk("clr_err", k, err_o[k], 8'h00);
            chk("clr_cnt", k, {5'b0, cnt_o[k]}, 8'h00);
        end
        step(8'h08, 16'h00C0, 8'h08, 8'h08, 1'b1);
        for (int k = 0; k < 4; k++)
            chk("clr_race_err", k, err_o[k], 8'h08);

        // Counter saturation with all channels toggling
        step(8'h00, 16'h0000, 8'h00, 8'h00, 1'b1);
        for (int s = 0; s < 10; s++) begin
            step(8'hFF, 16'h5555, 8'hFF, 8'h00, 1'b0);
            for (int k = 0; k < 4; k++) begin
                chk("sat_chg", k, chg_o[k], 8'hFF);
                chk("sat_cnt", k, {5'b0, cnt_o[k]}, (s < 7) ? 8'(s + 1) : 8'h07);
            end
        end

        // Asynchronous reset mid-run, away from any clock edge
        #2 rst = 1'b1;
        #1;
        chk_reset("rst_mid");
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        for (int s = 0; s < 10000; s++) begin
            step(8'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
                 ($urandom_range(0, 15) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
